// File: rtl/alu_pipe.sv
// alu_pipe: registered ARM-style ALU with valid/ready handshakes and NZCV flags.
// Optional iterative shift-add multiplier enabled by defining ALU_PIPE_MUL_EN.
module alu_pipe #(
    parameter int WIDTH           = 32,
    parameter int MUL_CYCLES_LOG2 = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [3:0]       alu_op,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             wr_en
);

    localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010, OP_RSB = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100, OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110, OP_MUL = 4'b0111;
    localparam logic [3:0] OP_TST = 4'b1000, OP_TEQ = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010, OP_CMN = 4'b1011;
    localparam logic [3:0] OP_ORR = 4'b1100, OP_MOV = 4'b1101;
    localparam logic [3:0] OP_BIC = 4'b1110, OP_MVN = 4'b1111;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             wr_en_q, wr_en_d;

    logic [WIDTH-1:0] add_a, add_b, alu_res;
    logic [WIDTH:0]   add_sum;
    logic             add_ci, is_arith, alu_c, alu_v, alu_wr;
    logic [3:0]       alu_flags;
    logic             accept;

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {IDLE, MUL_BUSY} state_t;
    state_t                   state_q, state_d;
    logic [WIDTH-1:0]         mul_acc_q, mul_acc_d;
    logic [WIDTH-1:0]         mul_mcand_q, mul_mcand_d;
    logic [WIDTH-1:0]         mul_mplier_q, mul_mplier_d;
    logic [MUL_CYCLES_LOG2-1:0] mul_cnt_q, mul_cnt_d;
    logic                     mul_c_q, mul_c_d;
    logic [WIDTH-1:0]         mul_step;

    assign in_ready = rst_n && (state_q == IDLE)
                      && (!out_valid_q || out_ready);
`else
    assign in_ready = rst_n && (!out_valid_q || out_ready);
`endif

    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
    assign wr_en     = wr_en_q;

    // Single-cycle datapath: shared adder plus full opcode decode
    always_comb begin
        add_a  = op1;
        add_b  = op2;
        add_ci = 1'b0;
        unique case (alu_op)
            OP_SUB, OP_CMP: begin
                add_b  = ~op2;
                add_ci = 1'b1;
            end
            OP_RSB: begin
                add_a  = op2;
                add_b  = ~op1;
                add_ci = 1'b1;
            end
            OP_ADC: add_ci = c_in;
            OP_SBC: begin
                add_b  = ~op2;
                add_ci = c_in;
            end
            default: ;
        endcase
        add_sum = {1'b0, add_a} + {1'b0, add_b}
                  + {{WIDTH{1'b0}}, add_ci};

        alu_res  = '0;
        is_arith = 1'b0;
        unique case (alu_op)
            OP_AND, OP_TST: alu_res = op1 & op2;
            OP_EOR, OP_TEQ: alu_res = op1 ^ op2;
            OP_SUB, OP_RSB, OP_ADD, OP_ADC,
            OP_SBC, OP_CMP, OP_CMN: begin
                alu_res  = add_sum[WIDTH-1:0];
                is_arith = 1'b1;
            end
            OP_MUL: alu_res = '0;
            OP_ORR: alu_res = op1 | op2;
            OP_MOV: alu_res = op2;
            OP_BIC: alu_res = op1 & ~op2;
            OP_MVN: alu_res = ~op2;
        endcase

        alu_c = is_arith ? add_sum[WIDTH] : c_in;
        alu_v = is_arith
                && (add_a[WIDTH-1] == add_b[WIDTH-1])
                && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
        alu_flags = {alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v};
        alu_wr    = (alu_op[3:2] != 2'b10);
    end

    // Next-state: output hold/clear, accept, and multiplier iteration
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        wr_en_d     = wr_en_q;
        if (out_valid_q && out_ready)
            out_valid_d = 1'b0;
`ifdef ALU_PIPE_MUL_EN
        state_d      = state_q;
        mul_acc_d    = mul_acc_q;
        mul_mcand_d  = mul_mcand_q;
        mul_mplier_d = mul_mplier_q;
        mul_cnt_d    = mul_cnt_q;
        mul_c_d      = mul_c_q;
        mul_step     = mul_acc_q
                       + (mul_mplier_q[0] ? mul_mcand_q : '0);
        unique case (state_q)
            IDLE: begin
                if (accept && alu_op == OP_MUL) begin
                    mul_acc_d    = '0;
                    mul_mcand_d  = op1;
                    mul_mplier_d = op2;
                    mul_cnt_d    = '0;
                    mul_c_d      = c_in;
                    state_d      = MUL_BUSY;
                end else if (accept) begin
                    result_d    = alu_res;
                    flags_d     = alu_flags;
                    wr_en_d     = alu_wr;
                    out_valid_d = 1'b1;
                end
            end
            MUL_BUSY: begin
                mul_acc_d    = mul_step;
                mul_mcand_d  = mul_mcand_q << 1;
                mul_mplier_d = mul_mplier_q >> 1;
                mul_cnt_d    = mul_cnt_q + 1'b1;
                if (mul_cnt_q == MUL_CYCLES_LOG2'(WIDTH - 1)) begin
                    result_d    = mul_step;
                    flags_d     = {mul_step[WIDTH-1], mul_step == '0,
                                   mul_c_q, 1'b0};
                    wr_en_d     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
`else
        if (accept) begin
            result_d    = alu_res;
            flags_d     = alu_flags;
            wr_en_d     = alu_wr;
            out_valid_d = 1'b1;
        end
`endif
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= 4'b0000;
            wr_en_q     <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
            state_q      <= IDLE;
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
            mul_c_q      <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            wr_en_q     <= wr_en_d;
`ifdef ALU_PIPE_MUL_EN
            state_q      <= state_d;
            mul_acc_q    <= mul_acc_d;
            mul_mcand_q  <= mul_mcand_d;
            mul_mplier_q <= mul_mplier_d;
            mul_cnt_q    <= mul_cnt_d;
            mul_c_q      <= mul_c_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed checks of alu_pipe with hand-computed vectors.
// Multiplier checks are built only when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op1, op2;
    logic [3:0]  alu_op;
    logic        c_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        wr_en;

    int n_checks = 0;
    int n_fail   = 0;

    alu_pipe #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .alu_op(alu_op), .c_in(c_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .wr_en(wr_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        in_valid = 1'b1;
        alu_op   = op;
        op1      = a;
        op2      = b;
        c_in     = c;
    endtask

    task automatic check_out(input string tag, input logic [31:0] r,
                             input logic [3:0] f, input logic w);
        check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
        check({tag, "_result"}, 64'(result), 64'(r));
        check({tag, "_flags"}, 64'(flags), 64'(f));
        check({tag, "_wr_en"}, 64'(wr_en), 64'(w));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; alu_op = '0; c_in = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1'b0));
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_flags", 64'(flags), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("post_rst_out_valid", 64'(out_valid), 64'(1'b0));

        // Stream of single-cycle ops with out_ready held high
        out_ready = 1'b1;
        issue(4'b0100, 32'h7FFF_FFFF, 32'h1, 1'b0); tick();
        check_out("add_ovf", 32'h8000_0000, 4'b1001, 1'b1);
        issue(4'b1010, 32'd5, 32'd5, 1'b0); tick();
        check_out("cmp_eq", 32'h0, 4'b0110, 1'b0);
        issue(4'b0010, 32'd0, 32'd1, 1'b0); tick();
        check_out("sub_neg", 32'hFFFF_FFFF, 4'b1000, 1'b1);
        issue(4'b0011, 32'd3, 32'd10, 1'b0); tick();
        check_out("rsb", 32'd7, 4'b0010, 1'b1);
        issue(4'b0110, 32'd10, 32'd3, 1'b0); tick();
        check_out("sbc", 32'd6, 4'b0010, 1'b1);
        issue(4'b1110, 32'h0000_F0F0, 32'h0000_00FF, 1'b1); tick();
        check_out("bic", 32'h0000_F000, 4'b0010, 1'b1);
        issue(4'b1111, 32'd0, 32'd0, 1'b0); tick();
        check_out("mvn", 32'hFFFF_FFFF, 4'b1000, 1'b1);
        issue(4'b1001, 32'hA5, 32'hA5, 1'b1); tick();
        check_out("teq", 32'h0, 4'b0110, 1'b0);
        in_valid = 1'b0; tick();
        check("drain_out_valid", 64'(out_valid), 64'(1'b0));

        // Backpressure: result held while downstream stalls
        out_ready = 1'b0;
        issue(4'b1100, 32'hF0, 32'h0F, 1'b0); tick();
        check_out("orr", 32'hFF, 4'b0000, 1'b1);
        check("bp_in_ready", 64'(in_ready), 64'(1'b0));
        issue(4'b0101, 32'd1, 32'd2, 1'b1); tick();
        check_out("orr_held", 32'hFF, 4'b0000, 1'b1);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 64'(in_ready), 64'(1'b1));
        tick();
        check_out("adc0", 32'd4, 4'b0000, 1'b1);
        issue(4'b0101, 32'hFFFF_FFFF, 32'd0, 1'b1); tick();
        check_out("adc1", 32'h0, 4'b0110, 1'b1);
        issue(4'b0101, 32'd5, 32'd6, 1'b0); tick();
        check_out("adc2", 32'd11, 4'b0000, 1'b1);
        in_valid = 1'b0; tick();
        check("drain2_out_valid", 64'(out_valid), 64'(1'b0));

`ifdef ALU_PIPE_MUL_EN
        begin
            int bad;
            issue(4'b0111, 32'h0001_0003, 32'h0000_0005, 1'b0); tick();
            in_valid = 1'b0;
            check("mul_accept_in_ready", 64'(in_ready), 64'(1'b0));
            bad = 0;
            for (int i = 1; i < 32; i++) begin
                tick();
                if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
            end
            check("mul_busy_quiet", 64'(bad), 64'(0));
            tick();
            check_out("mul", 32'h0005_000F, 4'b0000, 1'b1);
            tick();
            check("mul_drain", 64'(out_valid), 64'(1'b0));

            issue(4'b0111, 32'd7, 32'd9, 1'b0); tick();
            in_valid = 1'b0;
            for (int i = 0; i < 10; i++) tick();
            rst_n = 1'b0;
            #1;
            check("mul_abort_valid", 64'(out_valid), 64'(1'b0));
            check("mul_abort_in_ready", 64'(in_ready), 64'(1'b0));
            @(negedge clk);
            rst_n = 1'b1;
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid !== 1'b0) bad++;
            end
            check("mul_abort_no_valid", 64'(bad), 64'(0));
        end
`else
        issue(4'b0111, 32'd7, 32'd9, 1'b1); tick();
        check_out("mul_off", 32'h0, 4'b0110, 1'b1);
        in_valid = 1'b0; tick();
`endif

        // Asynchronous reset while a result is pending
        out_ready = 1'b0;
        issue(4'b1101, 32'd0, 32'h1234_5678, 1'b1); tick();
        in_valid = 1'b0;
        check_out("mov", 32'h1234_5678, 4'b0010, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(1'b0));
        check("arst_result", 64'(result), 64'(0));
        check("arst_flags", 64'(flags), 64'(0));
        check("arst_in_ready", 64'(in_ready), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_rel_in_ready", 64'(in_ready), 64'(1'b1));
        check("arst_rel_out_valid", 64'(out_valid), 64'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised successor to the combinational 32-bit datapath ALU.
- Adds a registered result with valid/ready handshakes, full ARM-style opcode decode, NZCV flag generation and an optional iterative multiplier.
- Sits between the register-read stage and writeback; result and flags are held until writeback accepts them.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 8).
- MUL_CYCLES_LOG2, $clog2(WIDTH), iteration counter width for the multiplier.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  block accepts operation this cycle
- op1  in  WIDTH  first operand (Rn)
- op2  in  WIDTH  second operand (shifter output)
- alu_op  in  4  opcode
- c_in  in  1  current C flag, used by ADC/SBC and by logical ops
- out_valid  out  1  result/flags valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- flags  out  4  registered {N,Z,C,V}
- wr_en  out  1  result must be written to Rd (0 for TST/TEQ/CMP/CMN)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, flags=4'b0000, wr_en=0, in_ready=0 while in reset; mul registers cleared.
- Opcodes:
  - 0000 AND, 0001 EOR, 0010 SUB, 0011 RSB (op2-op1), 0100 ADD, 0101 ADC (op1+op2+c_in), 0110 SBC (op1-op2-!c_in), 0111 MUL (low WIDTH bits), 1000 TST (AND), 1001 TEQ (EOR), 1010 CMP (SUB), 1011 CMN (ADD), 1100 ORR, 1101 MOV (op2), 1110 BIC (op1&~op2), 1111 MVN (~op2).
- Flags:
  - N=result[WIDTH-1]; Z=(result==0).
  - Arithmetic: C=carry out of the WIDTH-bit adder, where subtraction is done as op1+~op2+1, so C=1 means no borrow. V=signed overflow of that addition.
  - Logical ops and MOV/MVN: C=c_in, V=0.
  - MUL: C=c_in, V=0.
- wr_en=0 for 1000..1011, else 1; latched with result.
- States:
  - IDLE: in_ready = !out_valid || out_ready.
    - Accept (in_valid&&in_ready) of a non-MUL op: result/flags registered next edge, out_valid=1. Latency 1, throughput 1/cycle when out_ready held high.
    - Accept of MUL: operands latched, go to MUL_BUSY, out_valid deasserts at that edge if the old result was consumed.
  - MUL_BUSY: in_ready=0. Shift-add, one op2 bit per cycle, LSB first, counter 0..WIDTH-1.
    - After the final iteration, result/flags registered and out_valid=1; go to IDLE.
    - Total latency from accept edge to out_valid = WIDTH cycles.
- out_valid, result, flags and wr_en hold stable while out_valid && !out_ready. They clear to out_valid=0 on a handshake with no new accept the same cycle.
- Simultaneous out handshake and new accept: new result replaces old at the same edge with no bubble.
- Reset mid-MUL: operation discarded, outputs to reset values.
- Unknown-free: every opcode is defined; no default-zero path.

Optional Feature:
- Macro ALU_PIPE_MUL_EN.
- Defined: MUL (0111) implemented as above with the MUL_BUSY state.
- Undefined: no multiplier logic and no MUL_BUSY state. Opcode 0111 completes in 1 cycle with result=0, flags {0,1,c_in,0}, wr_en=1.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> out_valid=0, result=0, flags=0 immediately (async); after release, in_ready=1 with out_valid=0.
- ADD 32'h7FFFFFFF+1 (op 0100), out_ready=1 -> next cycle result=32'h80000000, flags N=1,Z=0,C=0,V=1, wr_en=1.
- CMP 5,5 (1010) -> result=0, flags N=0,Z=1,C=1,V=0, wr_en=0. SUB 0-1 (0010) -> 32'hFFFFFFFF, N=1,C=0.
- Backpressure: out_ready=0, issue ORR 32'hF0|32'h0F -> result=32'hFF held, in_ready=0; next op accepted the same cycle out_ready rises; back-to-back ADCs with out_ready=1 give one result per cycle.
- MUL (with ALU_PIPE_MUL_EN): 32'h0001_0003*32'h0000_0005 -> out_valid exactly 32 cycles after accept, result=32'h0005_000F, in_ready=0 throughout. Reset at cycle 10 -> aborted, no out_valid.
- Without the macro: MUL 7*9 -> 1-cycle result=0, Z=1, wr_en=1.
